// File: rtl/axi_lite_grid_regs.sv
// AXI4-Lite register file for the 4x4 Life controller: CTRL/SEED out to the grid, GRID/GEN status back.
// Optional AXI_LITE_SLVERR_EN: writes to the read-only GRID/GEN registers answer SLVERR instead of OKAY.
module axi_lite_grid_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   input  logic [15:0]                       grid_in,
   input  logic                              gen_tick,
   output logic                              run,
   output logic                              step_pulse,
   output logic [15:0]                       seed
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   logic          r_init;
   logic          r_aw_lat;
   logic [1:0]    r_aw_idx;
   logic          r_w_lat;
   logic [DW-1:0] r_wdata;
   logic [SW-1:0] r_wstrb;
   logic          r_bvalid;
   logic [1:0]    r_bresp;
   logic          r_rvalid;
   logic [DW-1:0] r_rdata;
   logic          r_run;
   logic          r_step;
   logic [DW-1:0] r_seed;
   logic [DW-1:0] r_gen;

   logic          w_awready;
   logic          w_wready;
   logic          w_arready;
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_ar_hs;
   logic          w_commit;
   logic          w_wr_ctrl;
   logic          w_wr_seed;
   logic          w_wr_ro;
   logic          w_clr_gen;
   logic          w_step;
   logic [DW-1:0] w_seed_nxt;
   logic [DW-1:0] w_rd_mux;
   logic          w_unused;

   // r_init keeps every ready low during reset and releases them one edge later
   assign w_awready = r_init & ~r_aw_lat & ~r_bvalid;
   assign w_wready  = r_init & ~r_w_lat & ~r_bvalid;
   assign w_arready = r_init & ~r_rvalid;

   assign w_aw_hs   = S_AXI_AWVALID & w_awready;
   assign w_w_hs    = S_AXI_WVALID & w_wready;
   assign w_ar_hs   = S_AXI_ARVALID & w_arready;

   assign w_commit  = r_aw_lat & r_w_lat;
   assign w_wr_ctrl = w_commit & (r_aw_idx == 2'd0);
   assign w_wr_seed = w_commit & (r_aw_idx == 2'd1);
   assign w_wr_ro   = w_commit & r_aw_idx[1];
   assign w_clr_gen = w_wr_ctrl & r_wstrb[0] & r_wdata[2];
   assign w_step    = w_wr_ctrl & r_wstrb[0] & r_wdata[1];

   assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], w_wr_ro};

   always_comb begin
      w_seed_nxt = r_seed;
      for (int b = 0; b < SW; b++) begin
         if (r_wstrb[b]) w_seed_nxt[b*8 +: 8] = r_wdata[b*8 +: 8];
      end
   end

   // Read data comes from current state, so a same-edge write commit is not visible yet
   always_comb begin
      w_rd_mux = '0;
      case (S_AXI_ARADDR[3:2])
         2'd0:    w_rd_mux = {{(DW-1){1'b0}}, r_run};
         2'd1:    w_rd_mux = r_seed;
         2'd2:    w_rd_mux = {{(DW-16){1'b0}}, grid_in};
         default: w_rd_mux = r_gen;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_init   <= 1'b0;
         r_aw_lat <= 1'b0;
         r_aw_idx <= 2'd0;
         r_w_lat  <= 1'b0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bvalid <= 1'b0;
         r_bresp  <= 2'b00;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_run    <= 1'b0;
         r_step   <= 1'b0;
         r_seed   <= '0;
         r_gen    <= '0;
      end else begin
         r_init <= 1'b1;

         if (w_aw_hs) begin
            r_aw_lat <= 1'b1;
            r_aw_idx <= S_AXI_AWADDR[3:2];
         end else if (w_commit) begin
            r_aw_lat <= 1'b0;
         end

         if (w_w_hs) begin
            r_w_lat <= 1'b1;
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end else if (w_commit) begin
            r_w_lat <= 1'b0;
         end

         if (w_commit) begin
            r_bvalid <= 1'b1;
`ifdef AXI_LITE_SLVERR_EN
            r_bresp  <= w_wr_ro ? 2'b10 : 2'b00;
`else
            r_bresp  <= 2'b00;
`endif
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end

         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end

         if (w_wr_ctrl && r_wstrb[0]) r_run <= r_wdata[0];
         if (w_wr_seed) r_seed <= w_seed_nxt;
         r_step <= w_step;

         if (w_clr_gen) begin
            r_gen <= '0;
         end else if (gen_tick) begin
            r_gen <= r_gen + DW'(1);
         end
      end
   end

   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = w_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign run           = r_run;
   assign step_pulse    = r_step;
   assign seed          = r_seed[15:0];

endmodule

// File: tb/tb_axi_lite_grid_regs.sv
// Directed bench for axi_lite_grid_regs: register map, channel ordering, backpressure, GEN counter, reset abort.
module tb_axi_lite_grid_regs;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [15:0] grid_in;
   logic        gen_tick;
   logic        run;
   logic        step_pulse;
   logic [15:0] seed;

`ifdef AXI_LITE_SLVERR_EN
   localparam logic [1:0] EXP_RO_RESP = 2'b10;
`else
   localparam logic [1:0] EXP_RO_RESP = 2'b00;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int step_cnt = 0;
   int b_cnt = 0;

   axi_lite_grid_regs dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .grid_in(grid_in), .gen_tick(gen_tick),
      .run(run), .step_pulse(step_pulse), .seed(seed)
   );

   always #5 ACLK = ~ACLK;

   always @(negedge ACLK) begin
      if (step_pulse === 1'b1) step_cnt++;
      if (S_AXI_BVALID === 1'b1 && S_AXI_BREADY === 1'b1) b_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- bus driver tasks ----------------
   task automatic issue_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int cyc = 0;
      S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      while (!(aw_done && w_done)) begin
         if (cyc >= 32) begin
            n_tests++; n_fail++;
            $display("FAIL write_handshake: aw_done=%0b w_done=%0b, required both 1", aw_done, w_done);
            break;
         end
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge ACLK); #1; cyc++;
         if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
         if (w_hs)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
   endtask

   task automatic send_aw(input logic [3:0] addr);
      bit hs = 0;
      int cyc = 0;
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      while (!hs) begin
         if (cyc >= 32) begin
            n_tests++; n_fail++;
            $display("FAIL aw_handshake: got no AWREADY, required 1");
            break;
         end
         hs = S_AXI_AWREADY;
         @(posedge ACLK); #1; cyc++;
      end
      S_AXI_AWVALID = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      bit hs = 0;
      int cyc = 0;
      S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      while (!hs) begin
         if (cyc >= 32) begin
            n_tests++; n_fail++;
            $display("FAIL w_handshake: got no WREADY, required 1");
            break;
         end
         hs = S_AXI_WREADY;
         @(posedge ACLK); #1; cyc++;
      end
      S_AXI_WVALID = 1'b0;
   endtask

   task automatic wait_b(output logic [1:0] resp);
      int cyc = 0;
      resp = 2'bxx;
      S_AXI_BREADY = 1'b1;
      while (S_AXI_BVALID !== 1'b1) begin
         if (cyc >= 32) begin
            n_tests++; n_fail++;
            $display("FAIL b_timeout: BVALID=%b, required 1", S_AXI_BVALID);
            break;
         end
         @(posedge ACLK); #1; cyc++;
      end
      if (S_AXI_BVALID === 1'b1) begin
         resp = S_AXI_BRESP;
         @(posedge ACLK); #1;
      end
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic issue_read(input logic [3:0] addr);
      bit hs = 0;
      int cyc = 0;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
      while (!hs) begin
         if (cyc >= 32) begin
            n_tests++; n_fail++;
            $display("FAIL ar_handshake: got no ARREADY, required 1");
            break;
         end
         hs = S_AXI_ARREADY;
         @(posedge ACLK); #1; cyc++;
      end
      S_AXI_ARVALID = 1'b0;
   endtask

   task automatic take_r(output logic [31:0] data, output logic [1:0] resp);
      int cyc = 0;
      data = 'x; resp = 2'bxx;
      S_AXI_RREADY = 1'b1;
      while (S_AXI_RVALID !== 1'b1) begin
         if (cyc >= 32) begin
            n_tests++; n_fail++;
            $display("FAIL r_timeout: RVALID=%b, required 1", S_AXI_RVALID);
            break;
         end
         @(posedge ACLK); #1; cyc++;
      end
      if (S_AXI_RVALID === 1'b1) begin
         data = S_AXI_RDATA; resp = S_AXI_RRESP;
         @(posedge ACLK); #1;
      end
      S_AXI_RREADY = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ARESET = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      n_tests++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_axi_outs: got %b, required 00000",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
      end
      n_tests++;
      if ({run, step_pulse, seed} !== 18'h0) begin
         n_fail++; $display("FAIL reset_outs: got run=%b step=%b seed=%h, required 0/0/0000", run, step_pulse, seed);
      end
      ARESET = 1'b0;
      n_tests++;
      if (S_AXI_AWREADY !== 1'b0) begin
         n_fail++; $display("FAIL ready_before_edge: AWREADY=%b, required 0", S_AXI_AWREADY);
      end
      @(posedge ACLK); #1;
      n_tests++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b, required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
   endtask

   task automatic test_basic_rw();
      logic [1:0] resp; logic [31:0] d; int s0;
      s0 = step_cnt;
      issue_write(4'h4, 32'h0101FFFF, 4'hF); wait_b(resp);
      n_tests++;
      if (resp !== 2'b00) begin n_fail++; $display("FAIL seed_bresp: got %b, required 00", resp); end
      n_tests++;
      if (seed !== 16'hFFFF) begin n_fail++; $display("FAIL seed_out: got %h, required ffff", seed); end
      issue_write(4'h0, 32'hABCD0001, 4'hF); wait_b(resp);
      n_tests++;
      if ({resp, run} !== 3'b001) begin n_fail++; $display("FAIL ctrl_write: got resp=%b run=%b, required 00/1", resp, run); end
      n_tests++;
      if (step_cnt !== s0) begin n_fail++; $display("FAIL no_step: got %0d pulses, required 0", step_cnt - s0); end
      issue_write(4'h0, 32'h00000003, 4'h1); wait_b(resp);
      repeat (2) @(posedge ACLK);
      #1;
      n_tests++;
      if (step_cnt !== s0 + 1) begin n_fail++; $display("FAIL step_pulse: got %0d cycles, required 1", step_cnt - s0); end
      issue_read(4'h4);
      n_tests++;
      if (S_AXI_RVALID !== 1'b1) begin n_fail++; $display("FAIL read_latency: RVALID=%b, required 1", S_AXI_RVALID); end
      take_r(d, resp);
      n_tests++;
      if ({d, resp} !== {32'h0101FFFF, 2'b00}) begin n_fail++; $display("FAIL seed_read: got %h/%b, required 0101ffff/00", d, resp); end
      issue_read(4'h0); take_r(d, resp);
      n_tests++;
      if (d !== 32'h00000001) begin n_fail++; $display("FAIL ctrl_read: got %h, required 00000001", d); end
      issue_write(4'h4, 32'h55555555, 4'h0); wait_b(resp);
      issue_read(4'h4); take_r(d, resp);
      n_tests++;
      if ({resp, d} !== {2'b00, 32'h0101FFFF}) begin n_fail++; $display("FAIL strb_zero: got %h, required 0101ffff", d); end
   endtask

   task automatic test_split_order();
      logic [1:0] resp; logic [31:0] d; int b0;
      b0 = b_cnt;
      send_w(32'hDEAD0011, 4'b0010);
      n_tests++;
      if ({S_AXI_WREADY, S_AXI_AWREADY} !== 2'b01) begin
         n_fail++; $display("FAIL w_latched_ready: got W=%b AW=%b, required 0/1", S_AXI_WREADY, S_AXI_AWREADY);
      end
      repeat (2) @(posedge ACLK);
      #1;
      n_tests++;
      if (S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL w_only_no_b: BVALID=%b, required 0", S_AXI_BVALID); end
      send_aw(4'h4); wait_b(resp);
      issue_read(4'h4); take_r(d, resp);
      n_tests++;
      if ({d, b_cnt - b0} !== {32'h010100FF, 32'd1}) begin
         n_fail++; $display("FAIL w_first: got %h b=%0d, required 010100ff b=1", d, b_cnt - b0);
      end
      b0 = b_cnt;
      send_aw(4'h4);
      n_tests++;
      if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b01) begin
         n_fail++; $display("FAIL aw_latched_ready: got AW=%b W=%b, required 0/1", S_AXI_AWREADY, S_AXI_WREADY);
      end
      repeat (2) @(posedge ACLK);
      #1;
      send_w(32'hDEAD5511, 4'b0010); wait_b(resp);
      issue_read(4'h4); take_r(d, resp);
      n_tests++;
      if ({d, b_cnt - b0} !== {32'h010155FF, 32'd1}) begin
         n_fail++; $display("FAIL aw_first: got %h b=%0d, required 010155ff b=1", d, b_cnt - b0);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp; logic [31:0] d; int cyc; int bad;
      issue_write(4'h4, 32'h01020304, 4'hF);
      cyc = 0;
      while (S_AXI_BVALID !== 1'b1 && cyc < 8) begin @(posedge ACLK); #1; cyc++; end
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) bad++;
         @(posedge ACLK); #1;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL b_hold: %0d unstable cycles, required 0", bad); end
      wait_b(resp);
      n_tests++;
      if ({resp, S_AXI_AWREADY} !== 3'b001) begin n_fail++; $display("FAIL b_release: resp=%b AWREADY=%b, required 00/1", resp, S_AXI_AWREADY); end
      issue_read(4'h4);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY} !== {1'b1, 32'h01020304, 1'b0}) bad++;
         @(posedge ACLK); #1;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL r_hold: %0d unstable cycles, required 0", bad); end
      take_r(d, resp);
      n_tests++;
      if (d !== 32'h01020304) begin n_fail++; $display("FAIL r_release: got %h, required 01020304", d); end
   endtask

   task automatic test_rw_same_cycle();
      logic [1:0] resp, rresp; logic [31:0] d;
      issue_write(4'h4, 32'h0A0B0C0D, 4'hF);
      issue_read(4'h4);
      take_r(d, rresp);
      wait_b(resp);
      n_tests++;
      if (d !== 32'h01020304) begin n_fail++; $display("FAIL rw_collide: got %h, required 01020304", d); end
      issue_read(4'h4); take_r(d, rresp);
      n_tests++;
      if (d !== 32'h0A0B0C0D) begin n_fail++; $display("FAIL rw_after: got %h, required 0a0b0c0d", d); end
   endtask

   task automatic test_gen();
      logic [1:0] resp; logic [31:0] d;
      for (int i = 0; i < 3; i++) begin
         gen_tick = 1'b1; @(posedge ACLK); #1;
         gen_tick = 1'b0; @(posedge ACLK); #1;
      end
      issue_read(4'hC); take_r(d, resp);
      n_tests++;
      if (d !== 32'h3) begin n_fail++; $display("FAIL gen_count: got %h, required 00000003", d); end
      issue_write(4'h0, 32'h00000004, 4'h1);
      gen_tick = 1'b1; @(posedge ACLK); #1;
      gen_tick = 1'b0;
      wait_b(resp);
      issue_read(4'hC); take_r(d, resp);
      n_tests++;
      if ({d, run} !== 33'h0) begin n_fail++; $display("FAIL gen_clear_wins: got %h run=%b, required 00000000/0", d, run); end
      gen_tick = 1'b1; @(posedge ACLK); #1;
      gen_tick = 1'b0;
      issue_read(4'hC); take_r(d, resp);
      n_tests++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL gen_after_clear: got %h, required 00000001", d); end
   endtask

   task automatic test_ro_regs();
      logic [1:0] resp, rresp; logic [31:0] d;
      grid_in = 16'hBEEF;
      issue_write(4'h8, 32'h12345678, 4'hF); wait_b(resp);
      n_tests++;
      if (resp !== EXP_RO_RESP) begin n_fail++; $display("FAIL grid_wr_resp: got %b, required %b", resp, EXP_RO_RESP); end
      issue_read(4'h8); take_r(d, rresp);
      n_tests++;
      if ({d, rresp} !== {32'h0000BEEF, 2'b00}) begin n_fail++; $display("FAIL grid_read: got %h/%b, required 0000beef/00", d, rresp); end
      issue_write(4'hC, 32'hFFFFFFFF, 4'hF); wait_b(resp);
      n_tests++;
      if (resp !== EXP_RO_RESP) begin n_fail++; $display("FAIL gen_wr_resp: got %b, required %b", resp, EXP_RO_RESP); end
      issue_read(4'hC); take_r(d, rresp);
      n_tests++;
      if ({d, seed} !== {32'h1, 16'h0C0D}) begin n_fail++; $display("FAIL ro_no_effect: gen=%h seed=%h, required 00000001/0c0d", d, seed); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] rresp; logic [31:0] d0, d4, dc; int bseen;
      send_aw(4'h4);
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
      send_w(32'hFFFFFFFF, 4'hF);
      bseen = 0;
      for (int i = 0; i < 6; i++) begin
         if (S_AXI_BVALID !== 1'b0) bseen++;
         @(posedge ACLK); #1;
      end
      n_tests++;
      if (bseen != 0) begin n_fail++; $display("FAIL reset_drops_aw: BVALID seen %0d cycles, required 0", bseen); end
      issue_read(4'h0); take_r(d0, rresp);
      issue_read(4'h4); take_r(d4, rresp);
      issue_read(4'hC); take_r(dc, rresp);
      n_tests++;
      if ({d0, d4, dc, run, seed} !== '0) begin
         n_fail++; $display("FAIL regs_after_reset: ctrl=%h seed=%h gen=%h run=%b seed_o=%h, required all 0", d0, d4, dc, run, seed);
      end
   endtask

   initial begin
      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b010; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b101; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      grid_in = 16'h0; gen_tick = 1'b0;
      test_reset();
      test_basic_rw();
      test_split_order();
      test_backpressure();
      test_rw_same_cycle();
      test_gen();
      test_ro_regs();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
